// File: rtl/bt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bt_pkg
// Description : Shared constants and FSM state type for the Bluetooth status
//               return path.
// Revision    : 1.0 - initial release
// ============================================================================
package bt_pkg;

    localparam logic [7:0] HEADER_DEFAULT    = 8'hA5;
    localparam int         PKT_BYTES         = 4;
    localparam int         CLKS_PER_BIT_9600 = 10417;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] bt_checksum(input logic [7:0] b1,
                                               input logic [7:0] b2);
        return b1 ^ b2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer with back-to-back chaining from STOP.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import bt_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);

    localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t          r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_data;
    logic               r_txd;
    logic               w_bit_end;

    assign w_bit_end = (r_cnt == c_CNT_MAX);
    // Decoded from registers only: marks the last stop-bit cycle so the
    // sequencer can chain the next byte with zero gap.
    assign done      = (r_state == STOP) && w_bit_end;
    assign txd       = r_txd;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_txd     <= 1'b1;
        end else begin
            r_cnt <= ((r_state == IDLE) || w_bit_end) ? '0 : r_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    r_txd <= 1'b1;
                    if (start) begin
                        r_data  <= data;
                        r_txd   <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_txd     <= r_data[0];
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_data[r_bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (start) begin
                            r_data  <= data;
                            r_txd   <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bt_status_tx.sv
`default_nettype none
// ============================================================================
// Module      : bt_status_tx
// Description : Sends a 4-byte status packet (header, track, volume/play,
//               checksum) on change or request; changes mid-packet coalesce.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_status_tx
    import bt_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_9600,
    parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] TRACK,
    input  logic [3:0] VOLUME,
    input  logic       PLAYING,
    input  logic       SEND_REQ,
    output logic       UART_TXD,
    output logic       BUSY,
    output logic       PKT_DONE
);

    localparam logic [1:0] c_LAST_BYTE = 2'(PKT_BYTES - 1);

    logic [7:0] w_status;
    logic [7:0] r_status_prev;
    logic [7:0] r_snap;
    logic       r_pending;
    logic       r_busy;
    logic       r_pkt_done;
    logic [1:0] r_byte_idx;

    logic       w_trigger;
    logic       w_launch;
    logic       w_next_byte;
    logic       w_ser_start;
    logic       w_ser_done;
    logic [7:0] w_b1;
    logic [7:0] w_b2;
    logic [7:0] w_b3;
    logic [7:0] w_ser_data;

    assign w_status    = {PLAYING, VOLUME, TRACK};
    assign w_trigger   = (w_status != r_status_prev) || SEND_REQ;
    assign w_launch    = !r_busy && r_pending;
    assign w_next_byte = r_busy && w_ser_done && (r_byte_idx != c_LAST_BYTE);
    assign w_ser_start = w_launch || w_next_byte;

    assign w_b1 = {5'b0, r_snap[2:0]};
    assign w_b2 = {r_snap[7], 3'b0, r_snap[6:3]};
    assign w_b3 = bt_checksum(w_b1, w_b2);

    // r_byte_idx names the byte currently on the wire; chaining loads the next.
    always_comb begin
        w_ser_data = HEADER;
        if (!w_launch) begin
            case (r_byte_idx)
                2'd0:    w_ser_data = w_b1;
                2'd1:    w_ser_data = w_b2;
                default: w_ser_data = w_b3;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_status_prev <= '0;
            r_snap        <= '0;
            r_pending     <= 1'b0;
            r_busy        <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_byte_idx    <= '0;
        end else begin
            r_status_prev <= w_status;
            r_pkt_done    <= 1'b0;

            // A trigger in the launch cycle wins so it earns its own follow-up.
            if (w_trigger) begin
                r_pending <= 1'b1;
            end else if (w_launch) begin
                r_pending <= 1'b0;
            end

            if (w_launch) begin
                r_busy     <= 1'b1;
                r_byte_idx <= '0;
                r_snap     <= w_status;
            end else if (r_busy && w_ser_done) begin
                if (r_byte_idx == c_LAST_BYTE) begin
                    r_busy     <= 1'b0;
                    r_pkt_done <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .CLK   (CLK),
        .RST   (RST),
        .start (w_ser_start),
        .data  (w_ser_data),
        .txd   (UART_TXD),
        .done  (w_ser_done)
    );

    assign BUSY     = r_busy;
    assign PKT_DONE = r_pkt_done;

endmodule
`default_nettype wire

// File: tb/tb_bt_status_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_status_tx
// Description : Directed self-checking bench for bt_status_tx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_status_tx;

    localparam int CPB  = 16;
    localparam int PKT  = 40 * CPB;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] track = '0;
    logic [3:0] volume = '0;
    logic       playing = 1'b0;
    logic       send_req = 1'b0;
    logic       uart_txd;
    logic       busy;
    logic       pkt_done;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic txd_log  [0:MAXC-1];
    logic busy_log [0:MAXC-1];
    logic done_log [0:MAXC-1];

    bt_status_tx #(
        .CLKS_PER_BIT (CPB),
        .HEADER       (8'hA5)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .TRACK    (track),
        .VOLUME   (volume),
        .PLAYING  (playing),
        .SEND_REQ (send_req),
        .UART_TXD (uart_txd),
        .BUSY     (busy),
        .PKT_DONE (pkt_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            txd_log[cyc]  = uart_txd;
            busy_log[cyc] = busy;
            done_log[cyc] = pkt_done;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int c);
        while (cyc < c) tick(1);
    endtask

    function automatic int find_fall(input int from, input int to);
        int lo = (from < 1) ? 1 : from;
        int hi = (to >= MAXC) ? MAXC - 1 : to;
        for (int c = lo; c <= hi; c++)
            if (txd_log[c-1] === 1'b1 && txd_log[c] === 1'b0) return c;
        return -1;
    endfunction

    function automatic int count_falls(input int from, input int to);
        int n = 0;
        int lo = (from < 1) ? 1 : from;
        int hi = (to >= MAXC) ? MAXC - 1 : to;
        for (int c = lo; c <= hi; c++)
            if (txd_log[c-1] === 1'b1 && txd_log[c] === 1'b0) n++;
        return n;
    endfunction

    function automatic int find_done(input int from, input int to);
        int lo = (from < 0) ? 0 : from;
        int hi = (to >= MAXC) ? MAXC - 1 : to;
        for (int c = lo; c <= hi; c++)
            if (done_log[c] === 1'b1) return c;
        return -1;
    endfunction

    // Samples each data bit of byte n mid-bit, relative to packet start s.
    function automatic logic [31:0] decode(input int s, input int n);
        logic [7:0] b;
        int base = s + 10 * CPB * n;
        if (s < 0 || base + 10 * CPB >= MAXC) return 32'hDEAD;
        for (int k = 0; k < 8; k++) b[k] = txd_log[base + CPB * (k + 1) + CPB / 2];
        return {24'h0, b};
    endfunction

    task automatic check_packet(input string tag, input int s, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        int d;
        int ss = (s < 0) ? 0 : s;
        check($sformatf("%s B0", tag), decode(s, 0), {24'h0, b0});
        check($sformatf("%s B1", tag), decode(s, 1), {24'h0, b1});
        check($sformatf("%s B2", tag), decode(s, 2), {24'h0, b2});
        check($sformatf("%s B3", tag), decode(s, 3), {24'h0, b3});
        d = find_done(ss, ss + PKT + 20);
        check($sformatf("%s done_latency", tag), d - ss, PKT);
        check($sformatf("%s busy_edge", tag), {30'h0, busy_log[ss+PKT-1], busy_log[ss+PKT]}, 32'h2);
        check($sformatf("%s done_width", tag), {31'h0, done_log[ss+PKT+1]}, 32'h0);
    endtask

    initial begin
        int c0, s, s1, s2, d1, errs, busy_hi;
        logic [7:0] pb [4];
        logic       e;

        // Reset with all inputs low.
        tick(3);
        check("rst_txd", {31'h0, uart_txd}, 1);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, pkt_done}, 0);
        rst = 1'b0;
        tick(50);
        check("rst_no_pkt", count_falls(4, cyc - 1), 0);
        busy_hi = 0;
        for (int c = 4; c < cyc; c++) if (busy_log[c] !== 1'b0) busy_hi++;
        check("rst_busy_quiet", busy_hi, 0);

        // Status change alone launches a packet.
        tick_to(60);
        c0 = cyc;
        track = 3'd5; volume = 4'd9; playing = 1'b1;
        tick_to(c0 + PKT + 40);
        s = find_fall(c0, cyc - 1);
        check("chg_launch", s - c0, 2);
        check_packet("chg", s, 8'hA5, 8'h05, 8'h89, 8'h8C);

        // Explicit request with unchanged status.
        c0 = cyc;
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
        tick_to(c0 + PKT + 40);
        s = find_fall(c0, cyc - 1);
        check("req_launch", s - c0, 2);
        check_packet("req", s, 8'hA5, 8'h05, 8'h89, 8'h8C);
        check("req_single", count_falls(s + PKT, cyc - 1), 0);

        // Every bit cycle of the request packet at its expected level.
        pb[0] = 8'hA5; pb[1] = 8'h05; pb[2] = 8'h89; pb[3] = 8'h8C;
        errs = (s < 1) ? 1 : 0;
        if (s >= 1) begin
            for (int b = 0; b < 40; b++) begin
                if (b % 10 == 0)      e = 1'b0;
                else if (b % 10 == 9) e = 1'b1;
                else                  e = pb[b / 10][(b % 10) - 1];
                for (int j = 0; j < CPB; j++)
                    if (txd_log[s + CPB * b + j] !== e) errs++;
            end
            if (txd_log[s - 1] !== 1'b1) errs++;
        end
        check("bit_width", errs, 0);

        // Two changes inside B1 coalesce into one follow-up packet.
        c0 = cyc;
        track = 3'd2; volume = 4'd0; playing = 1'b0;
        tick_to(c0 + 2 + 170);
        track = 3'd3;
        tick_to(c0 + 2 + 200);
        track = 3'd4;
        tick_to(c0 + 2 + 2 * PKT + 1 + 60);
        s1 = find_fall(c0, cyc - 1);
        check("coal_launch", s1 - c0, 2);
        check_packet("coal1", s1, 8'hA5, 8'h02, 8'h00, 8'h02);
        d1 = find_done(s1 < 0 ? 0 : s1, cyc - 1);
        s2 = find_fall(d1 < 0 ? 0 : d1, cyc - 1);
        check("coal_gap", s2 - d1, 1);
        check_packet("coal2", s2, 8'hA5, 8'h04, 8'h00, 8'h04);
        check("coal_count", count_falls((s2 < 0 ? 0 : s2) + PKT, cyc - 1), 0);

        // Return status to zero.
        c0 = cyc;
        track = 3'd0;
        tick_to(c0 + PKT + 40);
        s = find_fall(c0, cyc - 1);
        check_packet("zero", s, 8'hA5, 8'h00, 8'h00, 8'h00);

        // SEND_REQ coincident with a volume change: one packet only.
        c0 = cyc;
        volume = 4'd7;
        send_req = 1'b1;
        tick(1);
        send_req = 1'b0;
        tick_to(c0 + PKT + 80);
        s = find_fall(c0, cyc - 1);
        check("sim_launch", s - c0, 2);
        check_packet("sim", s, 8'hA5, 8'h00, 8'h07, 8'h07);
        check("sim_single", count_falls((s < 0 ? 0 : s) + PKT, cyc - 1), 0);

        // Reset during B2 bit 3 abandons the packet.
        c0 = cyc;
        volume = 4'd3;
        tick_to(c0 + 2 + 10 * CPB * 2 + CPB * 4 + 6);
        s = find_fall(c0, cyc - 1);
        check("mid_launch", s - c0, 2);
        rst = 1'b1;
        track = 3'd0; volume = 4'd0; playing = 1'b0;
        tick(1);
        check("mid_was_low", {31'h0, txd_log[cyc - 2]}, 0);
        check("mid_txd", {31'h0, uart_txd}, 1);
        check("mid_busy", {31'h0, busy}, 0);
        tick(1);
        rst = 1'b0;
        c0 = cyc;
        tick(60);
        check("mid_quiet", count_falls(c0, cyc - 1), 0);
        check("mid_idle_busy", {31'h0, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
